// File: rtl/rr_arb_4_1.sv
// Four-channel round-robin arbiter with one-entry buffers per channel and a
// registered valid/ready output stage that also counts completed transfers.
module rr_arb_4_1 #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [4*W-1:0]   in_data,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [3:0]   buf_v_q, buf_v_d;
  logic [W-1:0] buf_d_q [4];
  logic [1:0]   ptr_q;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic [3:0]   cap;
  logic         load;
  logic         xfer;

  assign in_ready = ~buf_v_q;
  assign cap      = in_valid & ~buf_v_q;
  assign xfer     = out_valid & out_ready;
  assign load     = (~out_valid | out_ready) & (|buf_v_q);

  // Scan from farthest offset down so the nearest valid channel after ptr wins.
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (buf_v_q[idx]) win = idx;
    end
  end

  // A granted buffer was valid, so it can never be captured into in the same cycle.
  always_comb begin
    buf_v_d = buf_v_q | cap;
    if (load) buf_v_d[win] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cap[i]) buf_d_q[i] <= in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q   <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      xfer_cnt  <= '0;
    end else begin
      buf_v_q <= buf_v_d;
      if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= buf_d_q[win];
        out_sel   <= win;
        ptr_q     <= win + 2'd1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Randomized scoreboard bench for rr_arb_4_1: a behavioural model predicts
// grants into a queue that a negedge monitor checks against the DUT.
module tb_rr_arb_4_1;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [4*W-1:0]   in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_sel;
  logic [CNT_W-1:0] xfer_cnt;

  rr_arb_4_1 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } grant_t;

  // Behavioural model: pending word per channel, rotating priority, output slot.
  bit     mv [4];
  int     md [4];
  int     mptr  = 0;
  bit     mov   = 0;
  int     mcnt  = 0;
  bit     armed = 0;
  grant_t expq[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) mv[i] = 0;
        mptr = 0;
        mov  = 0;
        mcnt = 0;
        expq.delete();
        armed = 1;
      end else if (armed) begin
        bit hs;
        bit any;
        bit capt [4];
        hs  = mov && out_ready;
        any = mv[0] || mv[1] || mv[2] || mv[3];
        for (int i = 0; i < 4; i++) capt[i] = in_valid[i] && !mv[i];
        if (hs) mcnt = (mcnt + 1) % (1 << CNT_W);
        if ((!mov || out_ready) && any) begin
          int     w;
          bit     found;
          grant_t g;
          w = 0;
          found = 0;
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (mptr + k) % 4;
            if (!found && mv[c]) begin
              w = c;
              found = 1;
            end
          end
          g.sel  = 2'(w);
          g.data = W'(md[w]);
          expq.push_back(g);
          mv[w] = 0;
          mptr  = (w + 1) % 4;
          mov   = 1;
        end else if (hs) begin
          mov = 0;
        end
        for (int i = 0; i < 4; i++) begin
          if (capt[i]) begin
            mv[i] = 1;
            md[i] = int'(in_data[i*W +: W]);
          end
        end
      end
    end
  end

  // Monitor: compares against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        logic [3:0] exp_rdy;
        for (int i = 0; i < 4; i++) exp_rdy[i] = !mv[i];
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(mov));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
        if (out_valid === 1'b1) begin
          if (expq.size() == 0) begin
            chk("unexpected_word", 32'(out_sel), 32'hffff_ffff);
          end else begin
            chk("out_sel", 32'(out_sel), 32'(expq[0].sel));
            chk("out_data", 32'(out_data), 32'(expq[0].data));
            if (out_ready) void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input bit r, input bit [3:0] v, input bit [4*W-1:0] d, input bit rdy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 16'h0, rdy);
  endtask

  initial begin
    // Reset then idle
    drive(1'b1, 4'h0, 16'h0, 1'b1);
    drive(1'b1, 4'h0, 16'h0, 1'b1);
    idle(5, 1'b1);
    // Single word on channel 2
    drive(1'b0, 4'b0100, 16'h0c00, 1'b1);
    idle(4, 1'b1);
    // Round robin from ptr=0 with a,b,c,d
    drive(1'b1, 4'h0, 16'h0, 1'b1);
    drive(1'b0, 4'hf, 16'hdcba, 1'b1);
    idle(6, 1'b1);
    // Rotation: grant channel 1, then load 0 and 3 together
    drive(1'b0, 4'b0010, 16'h0050, 1'b1);
    idle(3, 1'b1);
    drive(1'b0, 4'b1001, 16'h7003, 1'b1);
    idle(4, 1'b1);
    // Backpressure with all channels full
    drive(1'b0, 4'hf, 16'h4321, 1'b0);
    idle(4, 1'b0);
    idle(6, 1'b1);
    // Saturated traffic to wrap the counter
    for (int i = 0; i < 300; i++) drive(1'b0, 4'hf, 16'($urandom), 1'b1);
    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++)
      drive(1'b0, 4'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    // Mid-flight reset
    drive(1'b0, 4'hf, 16'($urandom), 1'b0);
    drive(1'b0, 4'hf, 16'($urandom), 1'b0);
    drive(1'b1, 4'h0, 16'h0, 1'b0);
    idle(3, 1'b1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb_4_1.md
Name: rr_arb_4_1

Overview:
- Four-channel round-robin arbiter with per-channel one-entry buffers and a registered valid/ready output stage.
- Sits directly upstream of the 4:1 select stage. Produces the 2-bit select index and the winning channel's data word.
- The registered out_sel drives the mux select. out_data carries the selected word for consumers that take it directly.

Parameters:
- W, 4, data width per channel.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-channel request; bit i belongs to channel i.
- in_data  input  4*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  4  per-channel accept.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  W  granted word.
- out_sel  output  2  index of the granted channel.
- xfer_cnt  output  CNT_W  count of completed output transfers.

Behaviour:
- Reset:
  - Applies at the clock edge while rst=1; it is synchronous, not asynchronous.
  - Clears buf_v[3:0]=0, ptr=0, out_valid=0, out_data=0, out_sel=0, xfer_cnt=0.
  - Buffer data registers need not be reset.
  - Reset asserted mid-transfer discards all buffered and output words. Nothing is replayed.
- Input side:
  - in_ready[i] = !buf_v[i]. This is purely combinational from state, with no path from out_ready.
  - When in_valid[i] & in_ready[i], the block captures buf_d[i]=in_data slice and sets buf_v[i]=1 next cycle.
  - in_data is ignored when in_valid is 0.
- Load condition: load = (!out_valid | out_ready) & (|buf_v).
- Winner selection:
  - Winner w is the first index with buf_v set, scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The 2-bit index arithmetic wraps naturally (3+1 -> 0).
- On load, next cycle:
  - out_valid=1, out_data=buf_d[w], out_sel=w.
  - buf_v[w]=0, ptr=w+1 mod 4.
- No load:
  - If out_valid & out_ready, then out_valid=0. out_data and out_sel hold their last values.
  - Otherwise all output state holds.
- Output stability: while out_valid=1 & out_ready=0, out_data and out_sel must not change. No load occurs in that condition.
- Latency and throughput:
  - A word accepted on input at edge N is visible on output after edge N+1 at the earliest.
  - Full throughput (one word per cycle) is sustained when at least one buffer is valid and out_ready=1.
  - Per-channel rate is at most one word per 2 cycles.
- xfer_cnt increments by 1 on every cycle with out_valid & out_ready. It wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - A granted channel's buffer cannot refill in the grant cycle, because in_ready was 0. It refills no earlier than the following cycle.
  - A transfer and a load in the same cycle is normal back-to-back operation. The counter increments and the new word replaces the old one.
- Empty: with no buf_v set and out_valid=0, outputs hold and ptr holds.
- Fairness: a continuously requesting channel waits at most 3 grants to other channels before its own grant.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then all in_valid=0 for 5 cycles.
  - Required response: out_valid=0, in_ready=4'hF, xfer_cnt=0, out_sel=0 throughout.
- Single word:
  - Stimulus: in_valid=4'b0100 with channel 2 data=4'hc for 1 cycle, out_ready=1.
  - Required response: in_ready[2]=0 the next cycle; out_valid=1 with out_data=c, out_sel=2 one cycle after capture; xfer_cnt=1 afterwards.
- Round robin:
  - Stimulus: all four channels hold one word each (a, b, c, d for channels 0-3), out_ready=1, ptr=0.
  - Required response: outputs (sel,data) = (0,a), (1,b), (2,c), (3,d) on consecutive cycles; xfer_cnt=4.
- Rotation after grant:
  - Stimulus: after channel 1 is granted, load channels 0 and 3 simultaneously.
  - Required response: channel 3 is granted before channel 0, since ptr=2.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while channels 0-3 are all full.
  - Required response: out_data and out_sel stay frozen on the first winner; xfer_cnt does not change; in_ready stays 0 for the three ungranted full channels; in_ready for the granted channel returns to 1 (its buffer was emptied by the load) unless it is refilled.
- Counter wrap and mid-flight reset:
  - Stimulus: drive 256 transfers with CNT_W=8.
  - Required response: xfer_cnt returns to 0.
  - Stimulus: assert rst while out_valid=1 and buffers are full.
  - Required response: next cycle out_valid=0, in_ready=4'hF, xfer_cnt=0.
